imem_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instruction words into the processor's instruction memory. It is the write side of the instruction-memory port, whose only reader is the fetch stage. It holds the processor core in reset while a frame is received, checks the frame's checksum, and releases the core when the frame is good. It sits between the board-level byte receiver and the instruction-memory write port, alongside the processor top level.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and frame constants for the program loader
package imem_loader_pkg;

  // Loader states; the top module re-expresses these as plain 3-bit constants.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Sync byte, two length bytes and the checksum byte wrap every payload.
  localparam int FRAME_OVERHEAD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-receiver and instruction-memory write bundle
interface imem_loader_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [15:0]       imem_wdata;
  logic              proc_reset;
  logic              load_done;
  logic              load_err;

  // Byte source / observer side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, proc_reset, load_done, load_err
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata, proc_reset, load_done, load_err
  );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction-memory loader with checksum gate
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_LEN_HI  = LEN_HI;
  localparam logic [2:0] S_LEN_LO  = LEN_LO;
  localparam logic [2:0] S_DATA_HI = DATA_HI;
  localparam logic [2:0] S_DATA_LO = DATA_LO;
  localparam logic [2:0] S_CHECK   = CHECK;
  localparam logic [2:0] S_DONE    = DONE;
  localparam logic [2:0] S_ERROR   = ERROR;

  logic [2:0]        state;
  logic              ready_q;
  logic [7:0]        len_hi;
  logic [15:0]       word_len;
  logic [15:0]       word_cnt;
  logic [7:0]        hi_byte;
  logic [7:0]        chk_acc;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;

  logic        accept;
  logic        is_sync;
  logic [15:0] rx_len;

  assign accept  = bus.rx_valid && ready_q;
  assign is_sync = (bus.rx_data == SYNC_BYTE);
  assign rx_len  = {len_hi, bus.rx_data};

  // Frame parser: consumes one byte per accepted edge, updates counters and issues word writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ready_q  <= 1'b0;
      len_hi   <= 8'h00;
      word_len <= 16'h0000;
      word_cnt <= 16'h0000;
      hi_byte  <= 8'h00;
      chk_acc  <= 8'h00;
      addr     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= 16'h0000;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (is_sync) begin
              state    <= S_LEN_HI;
              chk_acc  <= 8'h00;
              addr     <= '0;
              word_cnt <= 16'h0000;
            end
          end
          S_LEN_HI: begin
            len_hi  <= bus.rx_data;
            chk_acc <= chk_acc ^ bus.rx_data;
            state   <= S_LEN_LO;
          end
          S_LEN_LO: begin
            word_len <= rx_len;
            chk_acc  <= chk_acc ^ bus.rx_data;
            if (rx_len > 16'(MAX_WORDS)) begin
              state <= S_ERROR;
            end else if (rx_len == 16'h0000) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_byte <= bus.rx_data;
            chk_acc <= chk_acc ^ bus.rx_data;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: begin
            chk_acc  <= chk_acc ^ bus.rx_data;
            we_q     <= 1'b1;
            waddr_q  <= addr;
            wdata_q  <= {hi_byte, bus.rx_data};
            addr     <= addr + 1'b1;
            word_cnt <= word_cnt + 16'd1;
            state    <= (word_cnt + 16'd1 == word_len) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            state <= (bus.rx_data == chk_acc) ? S_DONE : S_ERROR;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.proc_reset = (state != S_DONE);
  assign bus.load_done  = (state == S_DONE);
  assign bus.load_err   = (state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W(ADDR_W),
    .MAX_WORDS(256),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  typedef wr_t wr_q_t[$];

  typedef struct {
    logic [127:0] bytes;
    int           nb;
    bit           gaps;
    bit           exp_done;
    bit           exp_err;
    int           exp_nw;
    logic [15:0]  w0;
    logic [15:0]  w1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  wr_q_t got;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: records every strobe and insists strobes never come back-to-back.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      got.push_back({16'(bus.imem_waddr), bus.imem_wdata});
      check("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = bus.imem_we;
  end

  // Reference: parse the byte stream directly from the frame rules.
  function automatic void model(input byte_q_t s, output wr_q_t w, output bit done, output bit err);
    int i;
    int n;
    logic [7:0] x;
    w = {};
    done = 1'b0;
    err = 1'b0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      done = 1'b0;
      err = 1'b0;
      if (i + 2 > s.size()) return;
      n = {s[i], s[i+1]};
      x = s[i] ^ s[i+1];
      i += 2;
      if (n > 256) begin
        err = 1'b1;
        continue;
      end
      for (int k = 0; k < n; k++) begin
        if (i + 2 > s.size()) return;
        w.push_back({16'(k), s[i], s[i+1]});
        x ^= s[i] ^ s[i+1];
        i += 2;
      end
      if (i >= s.size()) return;
      done = (s[i] == x);
      err = !done;
      i++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    t = 0;
    while (!bus.rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
  endtask

  task automatic send_queue(input byte_q_t q, input bit gaps);
    got = {};
    foreach (q[j]) send_byte(q[j], gaps);
    end_stream();
  endtask

  task automatic check_vs_model(input string name, input byte_q_t q);
    wr_q_t w;
    bit d;
    bit e;
    model(q, w, d, e);
    check({name, "_done"}, 32'(bus.load_done), 32'(d));
    check({name, "_err"}, 32'(bus.load_err), 32'(e));
    check({name, "_proc_reset"}, 32'(bus.proc_reset), 32'(!d));
    check({name, "_nwrites"}, 32'(got.size()), 32'(w.size()));
    if (got.size() == w.size()) begin
      foreach (w[k]) check({name, "_write"}, got[k], w[k]);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({name, "_we"}, 32'(bus.imem_we), 32'd0);
    check({name, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({name, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check({name, "_proc_reset"}, 32'(bus.proc_reset), 32'd1);
    check({name, "_done"}, 32'(bus.load_done), 32'd0);
    check({name, "_err"}, 32'(bus.load_err), 32'd0);
  endtask

  function automatic byte_q_t gen_frame();
    byte_q_t q;
    int n;
    logic [7:0] x;
    logic [7:0] b;
    repeat ($urandom_range(0, 3)) q.push_back(8'($urandom_range(0, 8'hA4)));
    q.push_back(8'hA5);
    case ($urandom_range(0, 9))
      0: n = 257 + $urandom_range(0, 100);
      1: n = 0;
      default: n = $urandom_range(1, 6);
    endcase
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    if (n <= 256) begin
      x = n[15:8] ^ n[7:0];
      for (int k = 0; k < 2 * n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      q.push_back(x);
    end
    return q;
  endfunction

  vec_t vecs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    byte_q_t q;

    vecs[0] = '{128'hA500021234ABCD42, 8, 1'b0, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{128'hA500010001FF, 6, 1'b0, 1'b0, 1'b1, 1, 16'h0001, 16'h0000};
    vecs[2] = '{128'hA50101, 3, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
    vecs[3] = '{128'hA500021234ABCD42, 8, 1'b0, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
    vecs[4] = '{128'hA5000000, 4, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
    vecs[5] = '{128'hA5000001, 4, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
    vecs[6] = '{128'h00FF5AA500021234ABCD42, 11, 1'b1, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
    vecs[7] = '{128'hA50001A55AFE, 6, 1'b0, 1'b1, 1'b0, 1, 16'hA55A, 16'h0000};

    // Reset state, with a sync byte offered while reset is held.
    bus.rx_data = 8'hA5;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("in_reset");
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("first_after_reset");
    @(negedge clk);
    #1;
    check("rx_ready_rises", 32'(bus.rx_ready), 32'd1);

    // Word-write latency and hold, then release on a good checksum.
    got = {};
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h5E, 1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
    check("lat_we", 32'(bus.imem_we), 32'd1);
    check("lat_waddr", 32'(bus.imem_waddr), 32'd0);
    check("lat_wdata", 32'(bus.imem_wdata), 32'hC35E);
    check("lat_proc_reset", 32'(bus.proc_reset), 32'd1);
    @(negedge clk);
    #1;
    check("hold_we", 32'(bus.imem_we), 32'd0);
    check("hold_wdata", 32'(bus.imem_wdata), 32'hC35E);
    check("hold_waddr", 32'(bus.imem_waddr), 32'd0);
    send_byte(8'h9C, 1'b0);
    end_stream();
    check("lat_done", 32'(bus.load_done), 32'd1);
    check("lat_release", 32'(bus.proc_reset), 32'd0);
    check("lat_err", 32'(bus.load_err), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      got = {};
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].bytes[8*(vecs[i].nb-1-j) +: 8], vecs[i].gaps);
      end_stream();
      check($sformatf("vec%0d_done", i), 32'(bus.load_done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i), 32'(bus.load_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_proc_reset", i), 32'(bus.proc_reset), 32'(!vecs[i].exp_done));
      check($sformatf("vec%0d_nwrites", i), 32'(got.size()), 32'(vecs[i].exp_nw));
      if (vecs[i].exp_nw >= 1 && got.size() >= 1) check($sformatf("vec%0d_w0", i), got[0], {16'h0000, vecs[i].w0});
      if (vecs[i].exp_nw >= 2 && got.size() >= 2) check($sformatf("vec%0d_w1", i), got[1], {16'h0001, vecs[i].w1});
    end

    // Largest legal frame: 256 words.
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h01);
    q.push_back(8'h00);
    begin
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h01;
      for (int k = 0; k < 512; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        x ^= b;
      end
      q.push_back(x);
    end
    send_queue(q, 1'b0);
    check_vs_model("max_len", q);
    if (got.size() == 256) check("max_len_last_addr", 32'(got[255].addr), 32'd255);

    // Randomized frames against the reference parser.
    for (int r = 0; r < 24; r++) begin
      q = gen_frame();
      send_queue(q, r[0]);
      check_vs_model($sformatf("rand%0d", r), q);
    end

    // Reset after the third data byte of a 4-word frame.
    got = {};
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midframe_reset");
    check("midframe_nwrites", 32'(got.size()), 32'd1);
    if (got.size() >= 1) check("midframe_w0", got[0], {16'h0000, 16'h1122});
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
